hub75_driver: RTL
=================

# hub75_driver

Serialises the two-column bundle from the frame manager onto a 64x64 1:32-scan HUB75 panel. It consumes `columns`, `col_num1` and `data_valid`, and produces the `hub75_ready` pulse that requests the next bundle. Each column pair is shown with binary-coded modulation over 3 bit-planes, which gives 9-bit colour (3 bits per channel). The driver is the last stage before the panel pins.

## Interface
- `NUM_ROWS`, 64: pixels per column, i.e. shift-register length per bit-plane.
- `SCAN_RATE`, 32: number of scan addresses. `ADDR_W = $clog2(SCAN_RATE)`.
- `RGB_RES`, 9: bits per pixel, laid out as R=[8:6], G=[5:3], B=[2:0]. `PLANES = RGB_RES/3`.
- `BASE_ON`, 8: OE-active cycles for plane 0. Plane b is lit for `BASE_ON<<b` cycles.
- `READY_TIMEOUT`, 1023: WAIT cycles allowed without `data_valid` before `hub75_ready` is re-pulsed.

Ports:
- `clk_in`, in, 1: system clock.
- `rst_in`, in, 1: reset, **asynchronous, active-high**.
- `columns`, in, [1:0][NUM_ROWS-1:0][RGB_RES-1:0]: [0] drives the top half, [1] the bottom half.
- `col_num1`, in, ADDR_W: scan address for the bundle.
- `data_valid`, in, 1: one-cycle strobe; `columns`/`col_num1` are valid in that cycle.
- `hub75_ready`, out, 1: one-cycle pulse requesting the next bundle.
- `rgb0`, out, 3: {R,G,B} bits for the top half.
- `rgb1`, out, 3: {R,G,B} bits for the bottom half.
- `addr`, out, ADDR_W: panel row address.
- `hub_clk`, out, 1: panel shift clock.
- `latch`, out, 1: panel latch/STB.
- `oe_n`, out, 1: output enable, active-low.

## Operation
States: READY → WAIT → SHIFT → LATCH → DISPLAY, then back to SHIFT (next plane) or READY (after the last plane).

- **READY**
  - Lasts one cycle with `hub75_ready=1`, then goes to WAIT.
  - `data_valid` in this cycle is ignored.
- **WAIT**
  - On `data_valid`: capture `columns` and `col_num1` into internal registers, set plane=0, pixel=0, phase=0, go to SHIFT.
  - A timeout counter increments every WAIT cycle. When it reaches `READY_TIMEOUT`, go to READY; this recovers an upstream that missed the edge.
- **SHIFT** (two cycles per pixel, pixel index 0..NUM_ROWS-1, pixel 0 first)
  - Phase 0: `rgb0` = bit `plane` of the R/G/B fields of captured column 0 at `pixel`; `rgb1` likewise from column 1; `hub_clk=0`.
  - Phase 1: `hub_clk=1`, rgb held.
  - After phase 1 of pixel NUM_ROWS-1, go to LATCH.
- **LATCH**
  - One cycle: `latch=1`, `oe_n=1`, `addr` ← captured `col_num1`.
- **DISPLAY**
  - `oe_n=0` for `BASE_ON<<plane` cycles.
  - Then if plane < PLANES-1: plane++, pixel=0, go to SHIFT.
  - Otherwise go to READY.
- `oe_n=1` in every state except DISPLAY. The panel is dark while shifting, which prevents ghosting.
- `data_valid` outside WAIT is ignored; the captured data is never modified mid-bundle.
- Captured registers change only on acceptance in WAIT.
- The on-time counter must be wide enough for `BASE_ON<<(PLANES-1)` with no truncation.

## Timing
- Reset values: state=READY, `hub75_ready=0`, `rgb0=rgb1=0`, `addr=0`, `hub_clk=0`, `latch=0`, `oe_n=1`; all counters 0.
- First cycle after reset deassertion: `hub75_ready=1`.
- Reset asserted mid-operation: outputs take their reset values immediately (async); the captured bundle is discarded.
- Per plane: 2·NUM_ROWS shift + 1 latch + `BASE_ON<<b` display. With defaults this is 129 + {8,16,32}.
- Full bundle: 443 cycles from acceptance to the next `hub75_ready` cycle, plus 1 cycle in READY.
- Upstream asserts `data_valid` one cycle after seeing `hub75_ready`, so WAIT normally lasts 1 cycle.
- All outputs are registered; no combinational path from inputs to pins.

## Structure
- Shared package `hub75_pkg`:
  - state enum `hub75_state_t`.
  - field-offset constants `R_MSB`, `G_MSB`, `B_MSB`.
  - `PLANES` derivation.
- One sub-module, `hub75_plane_select`: combinational. Given a captured column pair, a pixel index and a plane, it returns {`rgb0`,`rgb1`}. The FSM/counters stay in `hub75_driver`.

## Test plan
- **Reset release:** `hub75_ready` is high in exactly cycle 1 and low in cycle 2; `oe_n=1`.
- **Accept a bundle:** all pixels of column 0 = 9'b111_000_101, column 1 = 0, `col_num1=5`, `data_valid` in the WAIT cycle. Expect:
  - plane 0: `rgb0=3'b101`, `rgb1=0`, 64 `hub_clk` rising edges;
  - LATCH with `addr=5`;
  - `oe_n` low for 8, 16, 32 cycles;
  - plane 1: `rgb0=3'b100`;
  - next `hub75_ready` exactly 443 cycles after acceptance.
- **Pixel ordering:** column 0 pixel 0 = 9'h1FF, others 0. `rgb0=3'b111` only during the first shift pair of each plane.
- **Spurious data_valid:** pulse `data_valid` during SHIFT with different data. Latched output and `addr` are unchanged.
- **Timeout:** hold `data_valid=0`. `hub75_ready` re-pulses after 1 + `READY_TIMEOUT` cycles and repeats every period.
- **Mid-DISPLAY reset:** assert `rst_in` asynchronously. `oe_n` goes high the same cycle; after release, `hub75_ready` pulses once.

Source files
------------

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and pixel field layout
// for the HUB75 panel driver.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_READY,
    ST_WAIT,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } hub75_state_t;

  localparam int RGB_RES = 9;
  localparam int PLANES  = RGB_RES / 3;
  localparam int PL_W    = (PLANES > 1) ? $clog2(PLANES) : 1;

  localparam int R_MSB = RGB_RES - 1;
  localparam int G_MSB = R_MSB - PLANES;
  localparam int B_MSB = G_MSB - PLANES;

endpackage

// File: rtl/hub75_plane_select.sv
// hub75_plane_select: picks one bit-plane of one
// pixel from both captured half-panel columns.
import hub75_pkg::*;

module hub75_plane_select #(
  parameter int NUM_ROWS = 64,
  parameter int PIX_W    = $clog2(NUM_ROWS)
) (
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] cols_i,
  input  logic [PIX_W-1:0]                      pix_i,
  input  logic [PL_W-1:0]                       plane_i,
  output logic [2:0]                            rgb0_o,
  output logic [2:0]                            rgb1_o
);

  logic [RGB_RES-1:0] px0, px1;
  logic [PLANES-1:0]  r0, g0, b0;
  logic [PLANES-1:0]  r1, g1, b1;

  // split each pixel into channels, then take the plane bit
  always_comb begin
    px0    = cols_i[0][pix_i];
    px1    = cols_i[1][pix_i];
    r0     = px0[R_MSB -: PLANES];
    g0     = px0[G_MSB -: PLANES];
    b0     = px0[B_MSB -: PLANES];
    r1     = px1[R_MSB -: PLANES];
    g1     = px1[G_MSB -: PLANES];
    b1     = px1[B_MSB -: PLANES];
    rgb0_o = {r0[plane_i], g0[plane_i], b0[plane_i]};
    rgb1_o = {r1[plane_i], g1[plane_i], b1[plane_i]};
  end

endmodule

// File: rtl/hub75_driver.sv
// hub75_driver: shifts a captured column pair onto a
// 1:32-scan HUB75 panel with binary-coded modulation.
import hub75_pkg::*;

module hub75_driver #(
  parameter int NUM_ROWS      = 64,
  parameter int SCAN_RATE     = 32,
  parameter int BASE_ON       = 8,
  parameter int READY_TIMEOUT = 1023,
  parameter int ADDR_W        = $clog2(SCAN_RATE)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns,
  input  logic [ADDR_W-1:0]                    col_num1,
  input  logic                                 data_valid,
  output logic                                 hub75_ready,
  output logic [2:0]                           rgb0,
  output logic [2:0]                           rgb1,
  output logic [ADDR_W-1:0]                    addr,
  output logic                                 hub_clk,
  output logic                                 latch,
  output logic                                 oe_n
);

  localparam int PIX_W = $clog2(NUM_ROWS);
  localparam int TMO_W = $clog2(READY_TIMEOUT + 1);
  localparam int ON_W  = $clog2((BASE_ON << (PLANES - 1)) + 1);

  typedef logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] bundle_t;

  hub75_state_t      state_q, state_d;
  bundle_t           cap_q, cap_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [PL_W-1:0]   plane_q, plane_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              phase_q, phase_d;
  logic [ON_W-1:0]   on_q, on_d, on_len;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              ready_q, ready_d;
  logic [2:0]        rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic [2:0]        sel0, sel1;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hclk_q, hclk_d;
  logic              latch_q, latch_d;
  logic              oe_n_q, oe_n_d;

  hub75_plane_select #(
    .NUM_ROWS (NUM_ROWS),
    .PIX_W    (PIX_W)
  ) u_sel (
    .cols_i  (cap_d),
    .pix_i   (pix_d),
    .plane_i (plane_d),
    .rgb0_o  (sel0),
    .rgb1_o  (sel1)
  );

  // state, counters, captured bundle and pin registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_READY;
      cap_q   <= '0;
      row_q   <= '0;
      plane_q <= '0;
      pix_q   <= '0;
      phase_q <= 1'b0;
      on_q    <= '0;
      tmo_q   <= '0;
      ready_q <= 1'b0;
      rgb0_q  <= '0;
      rgb1_q  <= '0;
      addr_q  <= '0;
      hclk_q  <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      pix_q   <= pix_d;
      phase_q <= phase_d;
      on_q    <= on_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
      addr_q  <= addr_d;
      hclk_q  <= hclk_d;
      latch_q <= latch_d;
      oe_n_q  <= oe_n_d;
    end
  end

  // sequencing: capture, shift pairs, latch, weighted on-time
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    row_d   = row_q;
    plane_d = plane_q;
    pix_d   = pix_q;
    phase_d = phase_q;
    on_d    = on_q;
    tmo_d   = tmo_q;
    on_len  = ON_W'(BASE_ON) << plane_q;
    unique case (state_q)
      ST_READY: begin
        tmo_d = '0;
        if (ready_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (data_valid) begin
          cap_d   = columns;
          row_d   = col_num1;
          plane_d = '0;
          pix_d   = '0;
          phase_d = 1'b0;
          tmo_d   = '0;
          state_d = ST_SHIFT;
        end else if (tmo_q == TMO_W'(READY_TIMEOUT - 1)) begin
          tmo_d   = '0;
          state_d = ST_READY;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (pix_q == PIX_W'(NUM_ROWS - 1)) begin
            pix_d   = '0;
            state_d = ST_LATCH;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        on_d    = '0;
        state_d = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        on_d = on_q + 1'b1;
        if (on_q == on_len - 1'b1) begin
          on_d = '0;
          if (plane_q < PL_W'(PLANES - 1)) begin
            plane_d = plane_q + 1'b1;
            pix_d   = '0;
            phase_d = 1'b0;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_READY;
          end
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // pin values for the coming cycle, from the next state
  always_comb begin
    ready_d = (state_d == ST_READY);
    rgb0_d  = rgb0_q;
    rgb1_d  = rgb1_q;
    if (state_d == ST_SHIFT) begin
      rgb0_d = sel0;
      rgb1_d = sel1;
    end
    hclk_d  = (state_d == ST_SHIFT) && phase_d;
    latch_d = (state_d == ST_LATCH);
    oe_n_d  = (state_d != ST_DISPLAY);
    addr_d  = (state_d == ST_LATCH) ? row_q : addr_q;
  end

  assign hub75_ready = ready_q;
  assign rgb0        = rgb0_q;
  assign rgb1        = rgb1_q;
  assign addr        = addr_q;
  assign hub_clk     = hclk_q;
  assign latch       = latch_q;
  assign oe_n        = oe_n_q;

endmodule
